// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS-subset control FSM with memory-ready wait states and a wait-timeout watchdog.
// Optional trap on unknown opcodes is enabled by defining CTRL_TRAP_EN.
module controle_multiciclo #(
    parameter int ALUOP_W  = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               WriteLink,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         state,
    output logic               illegal,
    output logic               mem_timeout
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_BEQ   = 4'b0001;
    localparam logic [3:0] ALU_BNE   = 4'b0010;
    localparam logic [3:0] ALU_SLTI  = 4'b0011;
    localparam logic [3:0] ALU_SLTIU = 4'b0100;
    localparam logic [3:0] ALU_ANDI  = 4'b0101;
    localparam logic [3:0] ALU_ORI   = 4'b0110;
    localparam logic [3:0] ALU_XORI  = 4'b0111;
    localparam logic [3:0] ALU_LUI   = 4'b1000;
    localparam logic [3:0] ALU_RTYPE = 4'b1111;

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wait_cnt, cnt_d;
    logic [3:0]       alu_code;
    logic             timed_out;
    logic             set_timeout;
    logic             timeout_q;

    // A WAIT_MAX of zero leaves the counter idle, so the watchdog never fires.
    assign timed_out = (WAIT_MAX != 0) && (wait_cnt == CNT_W'(WAIT_MAX));

    function automatic logic [3:0] exec_code(input logic [5:0] op);
        case (op)
            OP_RTYPE: exec_code = ALU_RTYPE;
            OP_SLTI:  exec_code = ALU_SLTI;
            OP_SLTIU: exec_code = ALU_SLTIU;
            OP_ANDI:  exec_code = ALU_ANDI;
            OP_ORI:   exec_code = ALU_ORI;
            OP_XORI:  exec_code = ALU_XORI;
            OP_LUI:   exec_code = ALU_LUI;
            default:  exec_code = ALU_ADD;
        endcase
    endfunction

`ifdef CTRL_TRAP_EN
    logic set_illegal;
    logic illegal_q;
`endif

    // NOTE: no memories here; every register gets an explicit reset value so a
    // mid-instruction reset lands in IDLE with no strobes pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            state_q   <= state_d;
            wait_cnt  <= cnt_d;
            timeout_q <= timeout_q | set_timeout;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

`ifdef CTRL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | set_illegal;
        end
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign mem_timeout = timeout_q;
    assign state       = state_q;
    assign ALUOp       = ALUOP_W'(alu_code);

    always_comb begin
        // NOTE: every output gets a default before the case, so no branch can
        // leave a signal unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = '0;
        set_timeout = 1'b0;
`ifdef CTRL_TRAP_EN
        set_illegal = 1'b0;
`endif
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemToReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        WriteLink = 1'b0;
        ALUSrcB   = 2'b00;
        PCSource  = 2'b00;
        alu_code  = ALU_ADD;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end else if (WAIT_MAX != 0) begin
                    cnt_d = wait_cnt + CNT_W'(1);
                end
            end

            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI, OP_SLTIU, OP_LUI: state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default: begin
`ifdef CTRL_TRAP_EN
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end

            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD, S_MEMWRITE: begin
                IorD     = 1'b1;
                MemRead  = (state_q == S_MEMREAD);
                MemWrite = (state_q == S_MEMWRITE);
                if (mem_ready) begin
                    state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
                end else if (timed_out) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end else if (WAIT_MAX != 0) begin
                    cnt_d = wait_cnt + CNT_W'(1);
                end
            end

            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end

            S_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = (op_q == OP_RTYPE) ? 2'b00 : 2'b10;
                alu_code = exec_code(op_q);
                state_d  = S_ALUWB;
            end

            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_RTYPE);
                state_d  = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                PCSource = 2'b01;
                alu_code = (op_q == OP_BNE) ? ALU_BNE : ALU_BEQ;
                PCWrite  = (op_q == OP_BNE) ? ~zero : zero;
                state_d  = S_FETCH;
            end

            S_JUMP: begin
                PCSource  = 2'b10;
                PCWrite   = 1'b1;
                RegWrite  = (op_q == OP_JAL);
                WriteLink = (op_q == OP_JAL);
                state_d   = S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: the driver queues hand-written per-cycle
// expectations, and a negedge monitor pops and compares them (both CTRL_TRAP_EN builds).
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg;
    logic       RegDst, RegWrite, ALUSrcA, WriteLink;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [3:0] state;
    logic       illegal, mem_timeout;

    controle_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .WriteLink(WriteLink), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state(state), .illegal(illegal), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [1:0]  flg;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_flg;

    // Control vector order: PCWrite IRWrite IorD MemRead MemWrite MemToReg RegDst
    // RegWrite ALUSrcA WriteLink | ALUSrcB | PCSource | ALUOp
    function automatic logic [17:0] mk(input logic pcw, irw, iord, mr, mw, m2r, rd, rw, asa, wl,
                                       input logic [1:0] asb, pcs, input logic [3:0] aop);
        return {pcw, irw, iord, mr, mw, m2r, rd, rw, asa, wl, asb, pcs, aop};
    endfunction

    logic [17:0] c_none, c_f_rdy, c_f_wait, c_dec, c_maddr, c_mrd, c_mwb, c_mwr;
    logic [17:0] c_exec_r, c_wb_r, c_wb_i, c_j, c_jal;

    function automatic logic [17:0] c_exec_i(input logic [3:0] aop);
        return mk(0,0,0,0,0,0,0,0,1,0, 2'b10, 2'b00, aop);
    endfunction

    function automatic logic [17:0] c_br(input logic pcw, input logic [3:0] aop);
        return mk(pcw,0,0,0,0,0,0,0,1,0, 2'b00, 2'b01, aop);
    endfunction

    // Monitor: compares whatever the driver queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (state !== cur.st) begin
                errors++;
                $display("FAIL %s state: got %0d expected %0d", cur.name, state, cur.st);
            end
            checks++;
            if ({PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite,
                 ALUSrcA, WriteLink, ALUSrcB, PCSource, ALUOp} !== cur.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b expected %b", cur.name,
                         {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite,
                          ALUSrcA, WriteLink, ALUSrcB, PCSource, ALUOp}, cur.ctl);
            end
            checks++;
            if ({illegal, mem_timeout} !== cur.flg) begin
                errors++;
                $display("FAIL %s flags(illegal,timeout): got %b expected %b",
                         cur.name, {illegal, mem_timeout}, cur.flg);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic z, input logic [5:0] op,
                       input logic [3:0] st, input logic [17:0] ctl, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        e.st = st; e.ctl = ctl; e.flg = exp_flg; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Reset asserted for one cycle, then released; state is IDLE in both cycles.
    task automatic do_reset(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        exp_flg = 2'b00;
        e.st = 4'd0; e.ctl = c_none; e.flg = 2'b00; e.name = {nm, "_assert"};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e.name = {nm, "_release"};
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'd0; exp_flg = 2'b00;
        c_none   = '0;
        c_f_rdy  = mk(1,1,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 4'h0);
        c_f_wait = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 4'h0);
        c_dec    = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'h0);
        c_maddr  = mk(0,0,0,0,0,0,0,0,1,0, 2'b10, 2'b00, 4'h0);
        c_mrd    = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'h0);
        c_mwb    = mk(0,0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 4'h0);
        c_mwr    = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 4'h0);
        c_exec_r = mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 4'hF);
        c_wb_r   = mk(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 4'h0);
        c_wb_i   = mk(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 4'h0);
        c_j      = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 4'h0);
        c_jal    = mk(1,0,0,0,0,0,0,1,0,1, 2'b00, 2'b10, 4'h0);

        // R-type: 0,1,2,7,8,1
        do_reset("por");
        cyc(1, 0, 6'b000000, 4'd1, c_f_rdy,  "r_fetch");
        cyc(1, 0, 6'b000000, 4'd2, c_dec,    "r_decode");
        cyc(1, 0, 6'b111111, 4'd7, c_exec_r, "r_exec");
        cyc(1, 0, 6'b111111, 4'd8, c_wb_r,   "r_aluwb");
        // ADDI, ORI, SLTIU, LUI: EXEC uses op_q, so opcode is scrambled after DECODE
        cyc(1, 0, 6'b001000, 4'd1, c_f_rdy,        "addi_fetch");
        cyc(1, 0, 6'b001000, 4'd2, c_dec,          "addi_decode");
        cyc(1, 0, 6'b000000, 4'd7, c_exec_i(4'h0), "addi_exec");
        cyc(1, 0, 6'b000000, 4'd8, c_wb_i,         "addi_aluwb");
        cyc(1, 0, 6'b001101, 4'd1, c_f_rdy,        "ori_fetch");
        cyc(1, 0, 6'b001101, 4'd2, c_dec,          "ori_decode");
        cyc(1, 0, 6'b001101, 4'd7, c_exec_i(4'h6), "ori_exec");
        cyc(1, 0, 6'b001101, 4'd8, c_wb_i,         "ori_aluwb");
        cyc(1, 0, 6'b001011, 4'd1, c_f_rdy,        "sltiu_fetch");
        cyc(1, 0, 6'b001011, 4'd2, c_dec,          "sltiu_decode");
        cyc(1, 0, 6'b001011, 4'd7, c_exec_i(4'h4), "sltiu_exec");
        cyc(1, 0, 6'b001011, 4'd8, c_wb_i,         "sltiu_aluwb");
        cyc(1, 0, 6'b001111, 4'd1, c_f_rdy,        "lui_fetch");
        cyc(1, 0, 6'b001111, 4'd2, c_dec,          "lui_decode");
        cyc(1, 0, 6'b001111, 4'd7, c_exec_i(4'h8), "lui_exec");
        cyc(1, 0, 6'b001111, 4'd8, c_wb_i,         "lui_aluwb");
        // LW with three wait cycles in MEMREAD: 8 cycles total
        cyc(1, 0, 6'b100011, 4'd1, c_f_rdy, "lw_fetch");
        cyc(1, 0, 6'b100011, 4'd2, c_dec,   "lw_decode");
        cyc(1, 0, 6'b100011, 4'd3, c_maddr, "lw_memaddr");
        for (int i = 0; i < 3; i++) cyc(0, 0, 6'b100011, 4'd4, c_mrd, "lw_memread_wait");
        cyc(1, 0, 6'b100011, 4'd4, c_mrd,   "lw_memread_done");
        cyc(1, 0, 6'b100011, 4'd5, c_mwb,   "lw_memwb");
        // SW with one FETCH wait cycle
        cyc(0, 0, 6'b101011, 4'd1, c_f_wait, "sw_fetch_wait");
        cyc(1, 0, 6'b101011, 4'd1, c_f_rdy,  "sw_fetch");
        cyc(1, 0, 6'b101011, 4'd2, c_dec,    "sw_decode");
        cyc(1, 0, 6'b101011, 4'd3, c_maddr,  "sw_memaddr");
        cyc(1, 0, 6'b101011, 4'd6, c_mwr,    "sw_memwrite");
        // Branches: PCWrite follows zero combinationally
        cyc(1, 0, 6'b000100, 4'd1, c_f_rdy,        "beq1_fetch");
        cyc(1, 0, 6'b000100, 4'd2, c_dec,          "beq1_decode");
        cyc(1, 1, 6'b000100, 4'd9, c_br(1, 4'h1),  "beq_taken");
        cyc(1, 0, 6'b000100, 4'd1, c_f_rdy,        "beq0_fetch");
        cyc(1, 0, 6'b000100, 4'd2, c_dec,          "beq0_decode");
        cyc(1, 0, 6'b000100, 4'd9, c_br(0, 4'h1),  "beq_not_taken");
        cyc(1, 0, 6'b000101, 4'd1, c_f_rdy,        "bne0_fetch");
        cyc(1, 0, 6'b000101, 4'd2, c_dec,          "bne0_decode");
        cyc(1, 0, 6'b000101, 4'd9, c_br(1, 4'h2),  "bne_taken");
        cyc(1, 0, 6'b000101, 4'd1, c_f_rdy,        "bne1_fetch");
        cyc(1, 0, 6'b000101, 4'd2, c_dec,          "bne1_decode");
        cyc(1, 1, 6'b000101, 4'd9, c_br(0, 4'h2),  "bne_not_taken");
        // Jumps
        cyc(1, 0, 6'b000010, 4'd1,  c_f_rdy, "j_fetch");
        cyc(1, 0, 6'b000010, 4'd2,  c_dec,   "j_decode");
        cyc(1, 0, 6'b000010, 4'd10, c_j,     "j_jump");
        cyc(1, 0, 6'b000011, 4'd1,  c_f_rdy, "jal_fetch");
        cyc(1, 0, 6'b000011, 4'd2,  c_dec,   "jal_decode");
        cyc(1, 0, 6'b000011, 4'd10, c_jal,   "jal_jump");
        // Reset in the middle of an LW aborts to IDLE with nothing asserted
        cyc(1, 0, 6'b100011, 4'd1, c_f_rdy, "abort_fetch");
        cyc(1, 0, 6'b100011, 4'd2, c_dec,   "abort_decode");
        cyc(1, 0, 6'b100011, 4'd3, c_maddr, "abort_memaddr");
        do_reset("abort");
        // mem_ready rises on the exact timeout cycle: completes, no HALT
        cyc(1, 0, 6'b100011, 4'd1, c_f_rdy, "edge_fetch");
        cyc(1, 0, 6'b100011, 4'd2, c_dec,   "edge_decode");
        cyc(1, 0, 6'b100011, 4'd3, c_maddr, "edge_memaddr");
        for (int i = 0; i < 15; i++) cyc(0, 0, 6'b100011, 4'd4, c_mrd, "edge_memread_wait");
        cyc(1, 0, 6'b100011, 4'd4, c_mrd,   "edge_memread_done");
        cyc(1, 0, 6'b100011, 4'd5, c_mwb,   "edge_memwb");
        // FETCH starved for 16 cycles -> HALT with mem_timeout, held until reset
        for (int i = 0; i < 16; i++) cyc(0, 0, 6'b000000, 4'd1, c_f_wait, "to_fetch_wait");
        exp_flg = 2'b01;
        cyc(1, 0, 6'b000000, 4'd15, c_none, "to_halt");
        cyc(1, 0, 6'b000000, 4'd15, c_none, "to_halt_sticky");
        do_reset("to_clear");
        // Unknown opcode
        cyc(1, 0, 6'b111111, 4'd1, c_f_rdy, "ill_fetch");
        cyc(1, 0, 6'b111111, 4'd2, c_dec,   "ill_decode");
`ifdef CTRL_TRAP_EN
        exp_flg = 2'b10;
        cyc(1, 0, 6'b000000, 4'd15, c_none, "ill_halt");
        cyc(1, 0, 6'b000000, 4'd15, c_none, "ill_halt_sticky");
        do_reset("ill_clear");
`else
        cyc(1, 0, 6'b000000, 4'd1, c_f_rdy, "ill_nop_fetch");
        cyc(1, 0, 6'b000000, 4'd2, c_dec,   "ill_nop_decode");
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle control FSM for the MIPS-subset datapath; the sequential successor of the single-cycle decoder. It sequences each instruction through fetch/decode/execute/memory/writeback states and drives the same datapath controls per cycle. It adds a memory-ready handshake with wait states, a wait-timeout watchdog, and a parametrised ALUOp width. It sits between the instruction register (opcode source), the memory port and the shared-ALU multi-cycle datapath.

## Interface
- ALUOP_W, 4, ALUOp width (≥4); codes zero-extended.
- WAIT_MAX, 15, max consecutive `mem_ready`=0 cycles tolerated in a memory state; 0 disables the timeout.
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  IR[31:26]; sampled on the DECODE edge.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes access this cycle.
- PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA, WriteLink  out  1 each  datapath strobes/selects.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  ALUOP_W  ALU operation code.
- state  out  4  current state encoding.
- illegal, mem_timeout  out  1 each  sticky error flags.

## Operation
- State codes: IDLE 0, FETCH 1, DECODE 2, MEMADDR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, HALT 15.
- Opcode register `op_q` loaded on leaving DECODE; all later states decode `op_q`, never `opcode`.
- Outputs default to 0 in every state; only the listed signals are asserted.
- ALUOp codes: add 0000, BEQ 0001, BNE 0010, SLTI 0011, SLTIU 0100, ANDI 0101, ORI 0110, XORI 0111, LUI 1000, R-type 1111.
- IDLE: all outputs 0 -> FETCH.
- FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00; IRWrite and PCWrite asserted only while mem_ready=1; stay until mem_ready=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add. Next: LW/SW -> MEMADDR; R-type, ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LUI -> EXEC; BEQ/BNE -> BRANCH; J/JAL -> JUMP; other -> see Configuration.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add -> MEMREAD (LW) or MEMWRITE (SW).
- MEMREAD: MemRead, IorD=1; wait for mem_ready -> MEMWB. MEMWB: RegWrite, MemToReg -> FETCH.
- MEMWRITE: MemWrite, IorD=1; wait for mem_ready -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00 (R-type) else 10, ALUOp per opcode (ADDI = add) -> ALUWB.
- ALUWB: RegWrite, RegDst=1 only for R-type -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, PCSource=01, ALUOp 0001/0010; PCWrite = (BEQ & zero) | (BNE & ~zero) -> FETCH.
- JUMP: PCSource=10, PCWrite; JAL additionally RegWrite, WriteLink -> FETCH.
- Watchdog: counter increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0; cleared on mem_ready=1 or state change. Counter==WAIT_MAX with mem_ready=0 -> HALT, mem_timeout=1.
- HALT: all datapath outputs 0; exits only via reset.

## Timing
- Moore outputs from `state`/`op_q`, except FETCH IRWrite/PCWrite and BRANCH PCWrite (combinational on mem_ready/zero).
- Reset: state=IDLE, op_q=0, counter=0, illegal=0, mem_timeout=0, all outputs 0; reset mid-instruction aborts with no writes.
- Zero-wait latency: R-type/I-ALU 4, LW 5, SW 4, BEQ/BNE 3, J/JAL 3 cycles; each wait cycle adds 1.
- mem_ready rising on the exact timeout cycle counts as completion (no HALT).

## Configuration
- CTRL_TRAP_EN defined: unknown opcode in DECODE -> HALT, illegal=1 (sticky until reset).
- Undefined: unknown opcode treated as NOP, DECODE -> FETCH; illegal tied 0.

## Test plan
- Reset released, mem_ready=1, opcode 000000 -> states 0,1,2,7,8,1; ALUWB shows RegWrite=1, RegDst=1; EXEC ALUOp=1111.
- LW (100011), mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with RegWrite=1, MemToReg=1; total 8 cycles.
- BEQ with zero=1 -> PCWrite=1, PCSource=01 in BRANCH; zero=0 -> PCWrite=0; BNE inverted.
- JAL (000011) -> JUMP with PCWrite=1, RegWrite=1, WriteLink=1, PCSource=10.
- mem_ready held 0 in FETCH, WAIT_MAX=15 -> HALT (state=15), mem_timeout=1 after 16 cycles; rst_n low clears to IDLE.
- Opcode 111111: with CTRL_TRAP_EN -> HALT, illegal=1; without -> back to FETCH, no writes.
